arb_burst_req_gen: RTL and testbench
====================================

Name: arb_burst_req_gen

Overview:
- Upstream stage of the fixed-priority locked arbiter.
- Converts per-source burst commands (valid/ready plus beat count) into the arbiter's `req` and `lockIn` vectors.
- Tracks the registered `grant` returned by the arbiter and counts beats, so a multi-beat burst holds the grant until its last beat.
- Emits per-source beat strobes and a completion pulse to the data path.

Parameters:
- REQ_NUM, 4, number of sources; must match the arbiter.
- LEN_W, 4, width of the per-source burst length field (beats minus 1).
- TMO_W, 8, width of the wait-timeout counter (optional feature only).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- srcValid  input  REQ_NUM  source i presents a burst command.
- srcLen  input  REQ_NUM*LEN_W  burst length minus 1; slice i is [i*LEN_W +: LEN_W].
- srcReady  output  REQ_NUM  command accepted when srcValid[i] & srcReady[i].
- grant  input  REQ_NUM  registered grant from the arbiter.
- req  output  REQ_NUM  request to the arbiter.
- lockIn  output  REQ_NUM  lock request to the arbiter.
- beatVld  output  REQ_NUM  one beat of source i transfers this cycle.
- done  output  REQ_NUM  one-cycle pulse on the last beat of a burst.
- tmoErr  output  REQ_NUM  timeout pulse; port exists only with ARB_BURST_TMO_EN.

Behaviour:
- Reset (async, rst=1):
  - all per-source FSMs go to IDLE and the counters clear.
  - srcReady = all ones; req, lockIn, beatVld, done, tmoErr = 0.
- Each source runs an independent FSM with states IDLE, REQ, DRAIN.
- IDLE:
  - srcReady[i]=1, req[i]=0, lockIn[i]=0.
  - On srcValid[i]: latch srcLen slice into cnt[i] and move to REQ next cycle.
- REQ:
  - srcReady[i]=0, req[i]=1.
  - lockIn[i] = (cnt[i]!=0), so the final beat and single-beat bursts request no lock.
  - beatVld[i] = grant[i]. Combinational from grant; grant is already registered, so there is no extra latency.
  - On a beat with cnt!=0: decrement cnt.
  - On a beat with cnt==0: done[i]=1 and move to DRAIN.
- DRAIN:
  - srcReady[i]=0, req[i]=0, lockIn[i]=0, beatVld[i]=0.
  - Stay until grant[i]==0, then go to IDLE.
  - Reason: the arbiter's grant lags req by one cycle, so a stale grant must never count as a beat of the next burst.
- Latency:
  - Command accept to req high: 1 cycle.
  - req high to first beat: at least 1 cycle, set by the arbiter.
  - Last beat to srcReady: at least 2 cycles (DRAIN, then IDLE).
- Beat count per burst is exactly srcLen+1. cnt never underflows or wraps. srcLen = all ones gives 2^LEN_W beats.
- Grant not in REQ: grant[i] in IDLE or DRAIN is ignored for counting.
- Simultaneous events:
  - srcValid while in REQ/DRAIN is not accepted (srcReady=0); the source must hold it.
  - Multiple sources may sit in REQ at once; prioritisation is the arbiter's job.
- Reset mid-burst: the burst is discarded with no done pulse, and req/lockIn drop immediately (async).
- Sources are fully independent; there is no cross-source logic here.

Optional Feature:
- Macro: ARB_BURST_TMO_EN.
- With the macro:
  - per-source counter tmo[i] (TMO_W bits) clears on entry to REQ.
  - it increments each REQ cycle in which no beat has yet occurred.
  - at all ones: tmoErr[i] pulses 1 cycle, the burst is abandoned with no done, and the FSM goes to DRAIN.
  - once the first beat occurs, the counter is frozen.
- Without the macro: no tmo counter, no tmoErr port, and REQ waits indefinitely.

Decomposition:
- Package arb_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_REQ=2'd1, ST_DRAIN=2'd2.
  - default widths LEN_W and TMO_W.
- Sub-module arb_burst_src_fsm: one source's FSM, counter and timeout.
- The top replicates it REQ_NUM times via generate and only does vector slicing.

Test Plan:
- Single beat: src1 len=0, grant[1] returned 2 cycles later → beatVld[1]=1 and done[1]=1 in the same cycle; lockIn[1] never 1; srcReady[1] back 2 cycles after grant[1] drops.
- Burst of 4: src0 len=3, grant held → exactly 4 beatVld[0] pulses; lockIn[0]=1 for beats 1-3 and 0 on beat 4; done[0] on beat 4.
- Stale grant: grant[2] kept high 1 cycle after done[2] while srcValid[2]=1 → no extra beatVld[2]; new command accepted only after grant[2]=0.
- Contention: src0 len=1 and src3 len=2 accepted together, with the arbiter model granting src0 first → src0 gets 2 beats, then src3 gets 3 beats; no beatVld overlap.
- Reset mid-burst: rst=1 after 2 of 8 beats on src1 (len=7) → req/lockIn/beatVld/done = 0 immediately; srcReady=4'b1111.
- With ARB_BURST_TMO_EN and TMO_W=3: src2 requests, never granted → tmoErr[2] pulses after 7 REQ cycles; no done[2]; srcReady[2] high once grant[2]=0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants for the burst request generator that feeds the
// fixed-priority locked arbiter.
//   ST_*       : per-source FSM state encoding (IDLE / REQ / DRAIN)
//   DEF_LEN_W  : default burst length field width (beats minus 1)
//   DEF_TMO_W  : default wait-timeout counter width (ARB_BURST_TMO_EN builds)
package arb_pkg;

  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_REQ   = 2'd1;
  localparam logic [ST_W-1:0] ST_DRAIN = 2'd2;

  localparam int unsigned DEF_LEN_W = 4;
  localparam int unsigned DEF_TMO_W = 8;

endpackage

// File: rtl/arb_burst_src_fsm.sv
// One source's burst FSM: accepts a command, requests the arbiter, counts
// granted beats and drains any stale grant before accepting the next command.
// Optional macro ARB_BURST_TMO_EN adds a first-beat wait timeout.
// Ports:
//   clk, rst            : clock, async active-high reset
//   src_valid, src_len  : burst command (len = beats minus 1)
//   src_ready           : command accepted when src_valid & src_ready
//   grant               : registered grant from the arbiter
//   req, lock_in        : request / lock to the arbiter
//   beat_vld, done      : beat strobe, last-beat pulse
//   tmo_err             : timeout pulse (ARB_BURST_TMO_EN only)
module arb_burst_src_fsm
  import arb_pkg::*;
#(
  parameter int unsigned LEN_W = DEF_LEN_W,
  parameter int unsigned TMO_W = DEF_TMO_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             src_valid,
  input  logic [LEN_W-1:0] src_len,
  input  logic             grant,
  output logic             src_ready,
  output logic             req,
  output logic             lock_in,
  output logic             beat_vld,
  output logic             done
`ifdef ARB_BURST_TMO_EN
  ,
  output logic             tmo_err
`endif
);

  logic [ST_W-1:0]  state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             beat;
  logic             tmo_hit;

  // A grant only counts as a beat while requesting.
  assign beat = (state_q == ST_REQ) && grant;

`ifdef ARB_BURST_TMO_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             seen_q, seen_d;

  // Timeout only while still waiting for the first beat; a grant this cycle wins.
  assign tmo_hit = (state_q == ST_REQ) && !seen_q && !grant && (tmo_q == '1);
  assign tmo_err = tmo_hit;

  // Wait counter: cleared while idle, frozen once the first beat arrives.
  always_comb begin
    tmo_d  = tmo_q;
    seen_d = seen_q;
    if (state_q == ST_IDLE) begin
      tmo_d  = '0;
      seen_d = 1'b0;
    end else if ((state_q == ST_REQ) && !seen_q) begin
      if (grant) seen_d = 1'b1;
      else       tmo_d  = tmo_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      tmo_q  <= tmo_d;
      seen_q <= seen_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (src_valid) state_d = ST_REQ;
      ST_REQ:   if ((beat && (cnt_q == '0)) || tmo_hit) state_d = ST_DRAIN;
      ST_DRAIN: if (!grant) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Remaining-beat counter: loaded on accept, decremented per non-final beat.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == ST_IDLE) && src_valid) cnt_d = src_len;
    else if (beat && (cnt_q != '0))        cnt_d = cnt_q - LEN_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Outputs: decoded from state; beat strobes pass the registered grant through.
  always_comb begin
    src_ready = 1'b0;
    req       = 1'b0;
    lock_in   = 1'b0;
    beat_vld  = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: src_ready = 1'b1;
      ST_REQ: begin
        req      = 1'b1;
        lock_in  = (cnt_q != '0);
        beat_vld = grant;
        done     = grant && (cnt_q == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/arb_burst_req_gen.sv
// Burst request generator in front of the fixed-priority locked arbiter.
// Replicates one independent burst FSM per source; only vector slicing here.
// Optional macro ARB_BURST_TMO_EN adds the tmoErr port and wait timeout.
// Ports:
//   clk, rst        : clock, async active-high reset
//   srcValid/srcLen : per-source burst commands (slice i = [i*LEN_W +: LEN_W])
//   srcReady        : per-source command accept
//   grant           : registered grant from the arbiter
//   req, lockIn     : request / lock vectors to the arbiter
//   beatVld, done   : per-source beat strobe and last-beat pulse
//   tmoErr          : per-source timeout pulse (ARB_BURST_TMO_EN only)
module arb_burst_req_gen
  import arb_pkg::*;
#(
  parameter int unsigned REQ_NUM = 4,
  parameter int unsigned LEN_W   = DEF_LEN_W,
  parameter int unsigned TMO_W   = DEF_TMO_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REQ_NUM-1:0]       srcValid,
  input  logic [REQ_NUM*LEN_W-1:0] srcLen,
  output logic [REQ_NUM-1:0]       srcReady,
  input  logic [REQ_NUM-1:0]       grant,
  output logic [REQ_NUM-1:0]       req,
  output logic [REQ_NUM-1:0]       lockIn,
  output logic [REQ_NUM-1:0]       beatVld,
  output logic [REQ_NUM-1:0]       done
`ifdef ARB_BURST_TMO_EN
  ,
  output logic [REQ_NUM-1:0]       tmoErr
`endif
);

  for (genvar i = 0; i < REQ_NUM; i++) begin : g_src
    arb_burst_src_fsm #(
      .LEN_W (LEN_W),
      .TMO_W (TMO_W)
    ) u_fsm (
      .clk       (clk),
      .rst       (rst),
      .src_valid (srcValid[i]),
      .src_len   (srcLen[i*LEN_W +: LEN_W]),
      .grant     (grant[i]),
      .src_ready (srcReady[i]),
      .req       (req[i]),
      .lock_in   (lockIn[i]),
      .beat_vld  (beatVld[i]),
      .done      (done[i])
`ifdef ARB_BURST_TMO_EN
      ,
      .tmo_err   (tmoErr[i])
`endif
    );
  end

endmodule

// File: tb/tb_arb_burst_req_gen.sv
// Self-checking bench for arb_burst_req_gen: directed scenarios plus a
// randomized run compared cycle-by-cycle against a beat-counting model.
module tb_arb_burst_req_gen;

  localparam int N       = 4;
  localparam int LW      = 4;
  localparam int TW      = 3;
  localparam int TMO_MAX = 7;
`ifdef ARB_BURST_TMO_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  src_valid;
  logic [N*LW-1:0] src_len;
  logic [N-1:0]  src_ready, grant, req, lock_in, beat_vld, done;
  logic [N-1:0]  tmo_err;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: beats still owed per source, and whether it is waiting for grant to drop.
  int left[N];
  bit drn[N];
  int waited[N];
  bit got[N];

  always #5 clk = ~clk;

  arb_burst_req_gen #(.REQ_NUM(N), .LEN_W(LW), .TMO_W(TW)) dut (
    .clk      (clk),
    .rst      (rst),
    .srcValid (src_valid),
    .srcLen   (src_len),
    .srcReady (src_ready),
    .grant    (grant),
    .req      (req),
    .lockIn   (lock_in),
    .beatVld  (beat_vld),
    .done     (done)
`ifdef ARB_BURST_TMO_EN
    ,
    .tmoErr   (tmo_err)
`endif
  );

`ifndef ARB_BURST_TMO_EN
  assign tmo_err = '0;
`endif

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      left[i] = 0; drn[i] = 1'b0; waited[i] = 0; got[i] = 1'b0;
    end
  endtask

  task automatic model_out(output logic [N-1:0] rdy, rq, lk, bv, dn, te);
    for (int i = 0; i < N; i++) begin
      rdy[i] = !(left[i] > 0 || drn[i]);
      rq[i]  = left[i] > 0;
      lk[i]  = left[i] > 1;
      bv[i]  = rq[i] && grant[i];
      dn[i]  = bv[i] && left[i] == 1;
      te[i]  = TMO_EN && rq[i] && !got[i] && !grant[i] && waited[i] == TMO_MAX;
    end
  endtask

  task automatic model_tick();
    for (int i = 0; i < N; i++) begin
      if (drn[i]) begin
        if (!grant[i]) drn[i] = 1'b0;
      end else if (left[i] > 0) begin
        if (grant[i]) begin
          left[i]--; got[i] = 1'b1;
          if (left[i] == 0) drn[i] = 1'b1;
        end else if (TMO_EN && !got[i] && waited[i] == TMO_MAX) begin
          left[i] = 0; drn[i] = 1'b1;
        end else if (!got[i]) begin
          waited[i]++;
        end
      end else if (src_valid[i]) begin
        left[i] = int'(src_len[i*LW +: LW]) + 1;
        waited[i] = 0; got[i] = 1'b0;
      end
    end
  endtask

  // Registered fixed-priority locked arbiter, fed by the model's req/lock.
  function automatic logic [N-1:0] arb_next(input logic [N-1:0] rq, lk, gp);
    for (int i = 0; i < N; i++) if (gp[i] && rq[i] && lk[i]) return N'(1 << i);
    for (int i = 0; i < N; i++) if (rq[i]) return N'(1 << i);
    return '0;
  endfunction

  task automatic drv(input logic [N-1:0] v, input logic [N*LW-1:0] l, input logic [N-1:0] g);
    @(negedge clk);
    src_valid = v; src_len = l; grant = g;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; src_valid = '0; src_len = '0; grant = '0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; src_valid = '1; src_len = '1; grant = '1;
    #1;
    n_chk++; if (src_ready !== 4'hF) $display("FAIL reset_ready got=%b exp=1111", src_ready); else n_pass++;
    n_chk++; if ({req, lock_in, beat_vld, done, tmo_err} !== '0)
      $display("FAIL reset_outs got=%b exp=0", {req, lock_in, beat_vld, done, tmo_err}); else n_pass++;
    do_reset();
  endtask

  task automatic test_single_beat();
    do_reset();
    drv(4'b0010, '0, '0);
    n_chk++; if (src_ready[1] !== 1'b1) $display("FAIL single_idle_ready got=%b exp=1", src_ready[1]); else n_pass++;
    drv('0, '0, '0);
    n_chk++; if ({src_ready[1], req, lock_in} !== {1'b0, 4'b0010, 4'b0000})
      $display("FAIL single_req got=%b exp=0_0010_0000", {src_ready[1], req, lock_in}); else n_pass++;
    drv('0, '0, '0);
    drv('0, '0, 4'b0010);
    n_chk++; if ({beat_vld, done, lock_in} !== {4'b0010, 4'b0010, 4'b0000})
      $display("FAIL single_beat got=%b exp=0010_0010_0000", {beat_vld, done, lock_in}); else n_pass++;
    drv('0, '0, '0);
    n_chk++; if ({src_ready[1], req[1], beat_vld[1]} !== 3'b000)
      $display("FAIL single_drain got=%b exp=000", {src_ready[1], req[1], beat_vld[1]}); else n_pass++;
    drv('0, '0, '0);
    n_chk++; if (src_ready !== 4'hF) $display("FAIL single_ready_back got=%b exp=1111", src_ready); else n_pass++;
  endtask

  task automatic test_burst4();
    int beats = 0;
    do_reset();
    drv(4'b0001, 16'h0003, '0);
    drv('0, 16'h0003, '0);
    n_chk++; if ({req[0], lock_in[0]} !== 2'b11) $display("FAIL b4_req got=%b exp=11", {req[0], lock_in[0]}); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      drv('0, '0, 4'b0001);
      beats += int'(beat_vld[0]);
      n_chk++; if ({lock_in[0], done[0]} !== {k < 3, k == 3})
        $display("FAIL b4_beat%0d lock_done got=%b exp=%b", k, {lock_in[0], done[0]}, {k < 3, k == 3}); else n_pass++;
    end
    drv('0, '0, '0);
    beats += int'(beat_vld[0]);
    n_chk++; if (beats !== 4) $display("FAIL b4_count got=%0d exp=4", beats); else n_pass++;
    drv('0, '0, '0);
    n_chk++; if (src_ready !== 4'hF) $display("FAIL b4_ready got=%b exp=1111", src_ready); else n_pass++;
  endtask

  task automatic test_stale_grant();
    do_reset();
    drv(4'b0100, '0, '0);
    drv('0, '0, '0);
    drv('0, '0, 4'b0100);
    n_chk++; if ({beat_vld[2], done[2]} !== 2'b11) $display("FAIL stale_last got=%b exp=11", {beat_vld[2], done[2]}); else n_pass++;
    drv(4'b0100, 16'h0100, 4'b0100);
    n_chk++; if ({beat_vld[2], done[2], src_ready[2]} !== 3'b000)
      $display("FAIL stale_grant_beat got=%b exp=000", {beat_vld[2], done[2], src_ready[2]}); else n_pass++;
    drv(4'b0100, 16'h0100, '0);
    n_chk++; if (src_ready[2] !== 1'b0) $display("FAIL stale_drain_ready got=%b exp=0", src_ready[2]); else n_pass++;
    drv(4'b0100, 16'h0100, '0);
    n_chk++; if (src_ready[2] !== 1'b1) $display("FAIL stale_idle_ready got=%b exp=1", src_ready[2]); else n_pass++;
    drv('0, 16'h0100, '0);
    n_chk++; if ({req[2], lock_in[2]} !== 2'b11) $display("FAIL stale_new_req got=%b exp=11", {req[2], lock_in[2]}); else n_pass++;
  endtask

  task automatic test_contention();
    logic [N-1:0] rdy, rq, lk, bv, dn, te, prq, plk;
    int b0 = 0, b3 = 0, last0 = -1, first3 = -1;
    bit overlap = 1'b0;
    do_reset();
    prq = '0; plk = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      src_valid = (c == 0) ? 4'b1001 : 4'b0000;
      src_len   = 16'h2001;
      grant     = arb_next(prq, plk, grant);
      #1;
      model_out(rdy, rq, lk, bv, dn, te);
      n_chk++; if (beat_vld !== bv) $display("FAIL cont_beat c%0d got=%b exp=%b", c, beat_vld, bv); else n_pass++;
      if ($countones(beat_vld) > 1) overlap = 1'b1;
      if (beat_vld[0]) begin b0++; last0 = c; end
      if (beat_vld[3]) begin b3++; if (first3 < 0) first3 = c; end
      prq = rq; plk = lk;
      @(posedge clk);
      model_tick();
    end
    n_chk++; if ({b0, b3} !== {32'd2, 32'd3}) $display("FAIL cont_counts got=%0d,%0d exp=2,3", b0, b3); else n_pass++;
    n_chk++; if (overlap || first3 <= last0)
      $display("FAIL cont_order got overlap=%0d first3=%0d last0=%0d exp no overlap, first3>last0", overlap, first3, last0);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    drv(4'b0010, 16'h0070, '0);
    drv('0, '0, '0);
    drv('0, '0, 4'b0010);
    drv('0, '0, 4'b0010);
    drv('0, '0, 4'b0010);
    n_chk++; if ({req[1], lock_in[1], beat_vld[1]} !== 3'b111)
      $display("FAIL rmid_pre got=%b exp=111", {req[1], lock_in[1], beat_vld[1]}); else n_pass++;
    rst = 1'b1;
    #1;
    n_chk++; if ({req, lock_in, beat_vld, done} !== '0)
      $display("FAIL rmid_outs got=%b exp=0", {req, lock_in, beat_vld, done}); else n_pass++;
    n_chk++; if (src_ready !== 4'hF) $display("FAIL rmid_ready got=%b exp=1111", src_ready); else n_pass++;
    @(negedge clk);
    rst = 1'b0; grant = '0;
    model_reset();
  endtask

  task automatic test_timeout();
`ifdef ARB_BURST_TMO_EN
    int hit = -1;
    bit saw_done = 1'b0;
    do_reset();
    drv(4'b0100, '0, '0);
    for (int k = 1; k <= 12; k++) begin
      drv('0, '0, '0);
      if (done[2]) saw_done = 1'b1;
      if (tmo_err[2] && hit < 0) hit = k;
    end
    n_chk++; if (hit !== 8) $display("FAIL tmo_cycle got=%0d exp=8", hit); else n_pass++;
    n_chk++; if (saw_done || src_ready[2] !== 1'b1)
      $display("FAIL tmo_after got done=%0d ready=%b exp done=0 ready=1", saw_done, src_ready[2]); else n_pass++;
`endif
  endtask

  task automatic test_random();
    logic [N-1:0] rdy, rq, lk, bv, dn, te, prq, plk;
    do_reset();
    prq = '0; plk = '0;
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      src_valid = N'($urandom);
      src_len   = (N*LW)'($urandom);
      if ((c / 150) % 2 == 1) grant = arb_next(prq, plk, grant);
      else                    grant = N'($urandom);
      #1;
      model_out(rdy, rq, lk, bv, dn, te);
      n_chk++; if (src_ready !== rdy) $display("FAIL rnd_ready c%0d got=%b exp=%b", c, src_ready, rdy); else n_pass++;
      n_chk++; if (req !== rq)        $display("FAIL rnd_req c%0d got=%b exp=%b", c, req, rq); else n_pass++;
      n_chk++; if (lock_in !== lk)    $display("FAIL rnd_lock c%0d got=%b exp=%b", c, lock_in, lk); else n_pass++;
      n_chk++; if (beat_vld !== bv)   $display("FAIL rnd_beat c%0d got=%b exp=%b", c, beat_vld, bv); else n_pass++;
      n_chk++; if (done !== dn)       $display("FAIL rnd_done c%0d got=%b exp=%b", c, done, dn); else n_pass++;
`ifdef ARB_BURST_TMO_EN
      n_chk++; if (tmo_err !== te)    $display("FAIL rnd_tmo c%0d got=%b exp=%b", c, tmo_err, te); else n_pass++;
`endif
      prq = rq; plk = lk;
      @(posedge clk);
      model_tick();
    end
  endtask

  initial begin
    rst = 1'b1; src_valid = '0; src_len = '0; grant = '0;
    model_reset();
    test_reset();
    test_single_beat();
    test_burst4();
    test_stale_grant();
    test_contention();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
